// File: rtl/ft_recovery_ctrl.sv
// Lockstep recovery sequencer: halts both cores, restores their register
// files from the checkpoint copy, then restores the PC and releases them.
module ft_recovery_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int MAX_RETRY  = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  error_i,
    input  logic                  valid_instr_i,
    input  logic                  halted_i,
    output logic                  halt_o,
    output logic [ADDR_WIDTH-1:0] rf_raddr_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata_i,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  pc_restore_o,
    output logic                  recovering_o,
    output logic                  fail_o,
    output logic [CNT_WIDTH-1:0]  err_count_o
);

    // One extra bit so idx can reach NUM_REGS for the final write cycle.
    localparam int IDX_W = ADDR_WIDTH + 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        COPY,
        RESUME,
        FAIL
    } state_t;

    state_t          state;
    logic [IDX_W-1:0] idx;
    logic [RW-1:0]    retry_cnt;
    logic             detect;

    assign detect = valid_instr_i & error_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            idx         <= '0;
            retry_cnt   <= '0;
            err_count_o <= '0;
            fail_o      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (detect) begin
                        if (err_count_o != '1)
                            err_count_o <= err_count_o + CNT_WIDTH'(1);
                        if (retry_cnt == RETRY_MAX) begin
                            state  <= FAIL;
                            fail_o <= 1'b1;
                        end else begin
                            state     <= HALT;
                            retry_cnt <= retry_cnt + RW'(1);
                        end
                    end else if (valid_instr_i) begin
                        retry_cnt <= '0;
                    end
                end
                HALT: begin
                    if (halted_i) begin
                        state <= COPY;
                        idx   <= '0;
                    end
                end
                COPY: begin
                    if (idx == LAST_IDX) begin
                        state <= RESUME;
                        idx   <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                RESUME: state <= IDLE;
                FAIL:   state <= FAIL;
                default: state <= IDLE;
            endcase
        end
    end

    // Read leads write by one cycle to match the checkpoint RF latency.
    always_comb begin
        halt_o       = 1'b0;
        recovering_o = 1'b0;
        pc_restore_o = 1'b0;
        rf_we_o      = 1'b0;
        rf_raddr_o   = '0;
        rf_waddr_o   = '0;
        rf_wdata_o   = '0;
        unique case (state)
            IDLE: ;
            HALT: begin
                halt_o       = 1'b1;
                recovering_o = 1'b1;
            end
            COPY: begin
                halt_o       = 1'b1;
                recovering_o = 1'b1;
                if (idx < LAST_IDX)
                    rf_raddr_o = idx[ADDR_WIDTH-1:0];
                if (idx != '0) begin
                    rf_we_o    = 1'b1;
                    rf_waddr_o = idx[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
                    rf_wdata_o = rf_rdata_i;
                end
            end
            RESUME: begin
                halt_o       = 1'b1;
                recovering_o = 1'b1;
                pc_restore_o = 1'b1;
            end
            FAIL: halt_o = 1'b1;
            default: ;
        endcase
    end

endmodule
